ipgu_ram_ctrl: RTL and testbench

IPGU_RAM_CTRL -- requirements
Module: ipgu_ram_ctrl

---
 rtl/ipgu_pkg.sv | 29 ++
 rtl/ipgu_rr_arb2.sv | 41 ++++
 rtl/ipgu_ram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ipgu_ram_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipgu_pkg.sv
// Shared definitions for the image pixel buffer RAM controller: default geometry,
// controller states and the two-way round-robin pick used by the read arbiter.
package ipgu_pkg;

   localparam int IPGU_DATA_WIDTH = 8;
   localparam int IPGU_DEPTH_X    = 300;
   localparam int IPGU_DEPTH_Y    = 300;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_LOAD  = 2'd2,
      ST_SERVE = 2'd3
   } ipgu_state_e;

   // ptr names the requester that wins when both ask in the same cycle.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
      logic [1:0] gnt;
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
      return gnt;
   endfunction

endpackage

// File: rtl/ipgu_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from the request vector and a
// registered pointer that toggles after every grant.
module ipgu_rr_arb2
   import ipgu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_q;
   logic ptr_d;

   // Grant decode and pointer advance.
   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      if (en) begin
         gnt = rr_pick(req, ptr_q);
      end else begin
         gnt = 2'b00;
      end
      if (gnt != 2'b00) begin
         ptr_d = ~ptr_q;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ipgu_ram_ctrl.sv
// Frame loader and two-requester read server for a single-port image RAM.
// A frame is written in raster order (optionally after a one-cycle bulk clear), then reads are served.
module ipgu_ram_ctrl
   import ipgu_pkg::*;
#(
   parameter int DATA_WIDTH   = IPGU_DATA_WIDTH,
   parameter int DEPTH_X      = IPGU_DEPTH_X,
   parameter int DEPTH_Y      = IPGU_DEPTH_Y,
   parameter int ADDR_WIDTH_X = $clog2(DEPTH_X),
   parameter int ADDR_WIDTH_Y = $clog2(DEPTH_Y)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 clr_en,
   output logic                                 busy,
   output logic                                 frame_done,
   input  logic                                 pix_valid,
   input  logic [DATA_WIDTH-1:0]                pix_data,
   output logic                                 pix_ready,
   input  logic [1:0]                           rd_req,
   input  logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] rd_addr0,
   input  logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] rd_addr1,
   output logic [1:0]                           rd_gnt,
   output logic [1:0]                           rd_rvalid,
   output logic [DATA_WIDTH-1:0]                rd_rdata,
   output logic                                 rd_rerr,
   output logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]                ram_wrData,
   input  logic [DATA_WIDTH-1:0]                ram_rdData,
   output logic                                 ram_cs,
   output logic                                 ram_we,
   output logic                                 ram_wrAll
);

   localparam int AW = ADDR_WIDTH_X + ADDR_WIDTH_Y;
   localparam logic [ADDR_WIDTH_X-1:0] X_LAST = ADDR_WIDTH_X'(DEPTH_X - 1);
   localparam logic [ADDR_WIDTH_Y-1:0] Y_LAST = ADDR_WIDTH_Y'(DEPTH_Y - 1);

   ipgu_state_e             state_q, state_d;
   logic [ADDR_WIDTH_X-1:0] xcnt_q, xcnt_d;
   logic [ADDR_WIDTH_Y-1:0] ycnt_q, ycnt_d;
   logic                    frame_done_q, frame_done_d;
   logic [1:0]              rvalid_q, rvalid_d;
   logic                    rerr_q, rerr_d;

   logic                    arb_en_s;
   logic [1:0]              gnt_s;
   logic [AW-1:0]           gaddr_s;
   logic                    goor_s;

   function automatic logic out_of_range(input logic [AW-1:0] a);
      logic [ADDR_WIDTH_X-1:0] x;
      logic [ADDR_WIDTH_Y-1:0] y;
      x = a[ADDR_WIDTH_X-1:0];
      y = a[AW-1:ADDR_WIDTH_X];
      return (32'(x) >= 32'(DEPTH_X)) || (32'(y) >= 32'(DEPTH_Y));
   endfunction

   // A start request in SERVE takes the cycle, so arbitration is held off.
   assign arb_en_s = (state_q == ST_SERVE) && !start;

   ipgu_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .en  (arb_en_s),
      .req (rd_req),
      .gnt (gnt_s)
   );

   // Next-state, raster counters and RAM port command.
   always_comb begin
      state_d      = state_q;
      xcnt_d       = xcnt_q;
      ycnt_d       = ycnt_q;
      frame_done_d = 1'b0;
      rvalid_d     = 2'b00;
      rerr_d       = 1'b0;
      ram_cs       = 1'b0;
      ram_we       = 1'b0;
      ram_wrAll    = 1'b0;
      ram_addr     = {AW{1'b0}};
      ram_wrData   = {DATA_WIDTH{1'b0}};
      gaddr_s      = gnt_s[1] ? rd_addr1 : rd_addr0;
      goor_s       = out_of_range(gaddr_s);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = clr_en ? ST_CLEAR : ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_wrAll = 1'b1;
            state_d   = ST_LOAD;
         end
         ST_LOAD: begin
            if (pix_valid) begin
               ram_cs     = 1'b1;
               ram_we     = 1'b1;
               ram_addr   = {ycnt_q, xcnt_q};
               ram_wrData = pix_data;
               if (xcnt_q == X_LAST) begin
                  xcnt_d = {ADDR_WIDTH_X{1'b0}};
                  if (ycnt_q == Y_LAST) begin
                     ycnt_d       = {ADDR_WIDTH_Y{1'b0}};
                     frame_done_d = 1'b1;
                     state_d      = ST_SERVE;
                  end else begin
                     ycnt_d = ycnt_q + ADDR_WIDTH_Y'(1);
                  end
               end else begin
                  xcnt_d = xcnt_q + ADDR_WIDTH_X'(1);
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_SERVE: begin
            if (start) begin
               state_d = clr_en ? ST_CLEAR : ST_LOAD;
            end else if (gnt_s != 2'b00) begin
               ram_addr = gaddr_s;
               ram_cs   = !goor_s;
               rvalid_d = gnt_s;
               rerr_d   = goor_s;
            end else begin
               state_d = ST_SERVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state, counters and read-response pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         xcnt_q       <= {ADDR_WIDTH_X{1'b0}};
         ycnt_q       <= {ADDR_WIDTH_Y{1'b0}};
         frame_done_q <= 1'b0;
         rvalid_q     <= 2'b00;
         rerr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         xcnt_q       <= xcnt_d;
         ycnt_q       <= ycnt_d;
         frame_done_q <= frame_done_d;
         rvalid_q     <= rvalid_d;
         rerr_q       <= rerr_d;
      end
   end

   // Status and response outputs; read data comes straight from the RAM the cycle after the grant.
   always_comb begin
      rd_gnt     = gnt_s;
      rd_rvalid  = rvalid_q;
      rd_rerr    = rerr_q;
      frame_done = frame_done_q;
      busy       = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
      pix_ready  = (state_q == ST_LOAD);
      if ((rvalid_q != 2'b00) && !rerr_q) begin
         rd_rdata = ram_rdData;
      end else begin
         rd_rdata = {DATA_WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_ipgu_ram_ctrl.sv
// Bench for ipgu_ram_ctrl: a 4x3 instance with a RAM model and scoreboards,
// plus a default 300x300 instance loading a full frame in parallel.
module tb_ipgu_ram_ctrl;

   localparam int DX = 4, DY = 3, DW = 8, AW = 4;
   localparam int BX = 300, BY = 300, BAW = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, clr_en, pix_valid;
   logic [DW-1:0] pix_data;
   logic          busy, frame_done, pix_ready;
   logic [1:0]    rd_req, rd_gnt, rd_rvalid;
   logic [AW-1:0] rd_addr0, rd_addr1, ram_addr;
   logic [DW-1:0] rd_rdata, ram_wrData;
   logic [DW-1:0] ram_rdData = 8'h00;
   logic          rd_rerr, ram_cs, ram_we, ram_wrAll;

   ipgu_ram_ctrl #(.DATA_WIDTH(DW), .DEPTH_X(DX), .DEPTH_Y(DY)) dut (
      .clk(clk), .rst(rst), .start(start), .clr_en(clr_en), .busy(busy),
      .frame_done(frame_done), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(pix_ready), .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_rerr(rd_rerr),
      .ram_addr(ram_addr), .ram_wrData(ram_wrData), .ram_rdData(ram_rdData),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_wrAll(ram_wrAll)
   );

   logic           b_rst, b_start, b_clr_en, b_pix_valid;
   logic [7:0]     b_pix_data;
   logic           b_busy, b_frame_done, b_pix_ready;
   logic [1:0]     b_rd_req, b_rd_gnt, b_rd_rvalid;
   logic [BAW-1:0] b_rd_addr0, b_rd_addr1, b_ram_addr;
   logic [7:0]     b_rd_rdata, b_ram_wrData, b_ram_rdData;
   logic           b_rd_rerr, b_ram_cs, b_ram_we, b_ram_wrAll;
   assign b_ram_rdData = 8'h00;

   ipgu_ram_ctrl big (
      .clk(clk), .rst(b_rst), .start(b_start), .clr_en(b_clr_en), .busy(b_busy),
      .frame_done(b_frame_done), .pix_valid(b_pix_valid), .pix_data(b_pix_data),
      .pix_ready(b_pix_ready), .rd_req(b_rd_req), .rd_addr0(b_rd_addr0), .rd_addr1(b_rd_addr1),
      .rd_gnt(b_rd_gnt), .rd_rvalid(b_rd_rvalid), .rd_rdata(b_rd_rdata), .rd_rerr(b_rd_rerr),
      .ram_addr(b_ram_addr), .ram_wrData(b_ram_wrData), .ram_rdData(b_ram_rdData),
      .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_wrAll(b_ram_wrAll)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Synchronous single-port RAM model for the small instance.
   logic [DW-1:0] mem [0:15];
   always @(posedge clk) begin
      if (ram_cs && ram_we) begin
         if (ram_wrAll) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
         end else begin
            mem[ram_addr] <= ram_wrData;
         end
      end
      if (ram_cs && !ram_we) ram_rdData <= mem[ram_addr];
   end

   typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
   typedef struct packed { logic [1:0] id; logic [DW-1:0] data; logic err; } rd_exp_t;
   wr_exp_t wr_q[$];
   rd_exp_t rd_q[$];
   wr_exp_t wr_e;
   rd_exp_t rd_e;
   int fd_cnt = 0;

   // Scoreboard: pixel writes and read responses popped as the DUT produces them.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (ram_cs && ram_we && !ram_wrAll) begin
            if (wr_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL wr_unexpected actual=%0h/%0h required=none", ram_addr, ram_wrData);
            end else begin
               wr_e = wr_q.pop_front();
               chk("wr_addr", 32'(ram_addr), 32'(wr_e.addr));
               chk("wr_data", 32'(ram_wrData), 32'(wr_e.data));
            end
         end
         if (rd_rvalid != 2'b00) begin
            if (rd_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rd_unexpected actual=%0h required=none", rd_rvalid);
            end else begin
               rd_e = rd_q.pop_front();
               chk("rd_rvalid", 32'(rd_rvalid), 32'(rd_e.id));
               chk("rd_rdata", 32'(rd_rdata), 32'(rd_e.data));
               chk("rd_rerr", 32'(rd_rerr), 32'(rd_e.err));
            end
         end
         if (frame_done) fd_cnt++;
      end
   end

   function automatic rd_exp_t exp_rd(input logic [1:0] id, input logic [AW-1:0] a, input logic [7:0] base);
      logic [1:0] x, y;
      x = a[1:0];
      y = a[3:2];
      if (int'(y) >= DY) return {id, 8'h00, 1'b1};
      return {id, 8'(base + 8'(y) * 8'd4 + 8'(x)), 1'b0};
   endfunction

   typedef struct {
      logic [1:0] req; logic [3:0] a0; logic [3:0] a1; logic st;
      logic [1:0] gnt; logic cs; logic [3:0] addr; logic busy; logic fd;
   } vec_t;

   task automatic small_test();
      vec_t vt[7];
      rst = 1'b1; start = 1'b0; clr_en = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
      rd_req = 2'b00; rd_addr0 = 4'h0; rd_addr1 = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'({busy, frame_done, pix_ready, rd_gnt, rd_rvalid, rd_rerr,
                                rd_rdata, ram_cs, ram_we, ram_wrAll}), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      start = 1'b1; clr_en = 1'b1;
      @(negedge clk);
      chk("idle_quiet", 32'({busy, ram_cs, pix_ready}), 32'h0);
      @(posedge clk); #1 start = 1'b0; clr_en = 1'b0;
      @(negedge clk);
      chk("clear_cycle", 32'({ram_cs, ram_we, ram_wrAll, busy, pix_ready}), 32'b11110);
      @(posedge clk); #1;
      rd_req = 2'b11; rd_addr0 = 4'b0110; rd_addr1 = 4'b1011;
      for (int p = 0; p < 12; p++) begin
         if ((p % 3) == 1) begin
            pix_valid = 1'b0;
            @(negedge clk);
            chk("load_gap", 32'({ram_cs, pix_ready, rd_gnt}), 32'b0100);
            @(posedge clk); #1;
         end
         pix_valid = 1'b1;
         pix_data  = 8'h10 + 8'(p);
         wr_q.push_back({2'(p / DX), 2'(p % DX), 8'h10 + 8'(p)});
         @(negedge clk);
         chk("load_state", 32'({busy, pix_ready, ram_wrAll, rd_gnt, frame_done}), 32'b110000);
         @(posedge clk); #1;
      end
      pix_valid = 1'b0;
      vt[0] = '{2'b11, 4'h6, 4'hB, 1'b0, 2'b01, 1'b1, 4'h6, 1'b0, 1'b1};
      vt[1] = '{2'b11, 4'h6, 4'hB, 1'b0, 2'b10, 1'b1, 4'hB, 1'b0, 1'b0};
      vt[2] = '{2'b11, 4'h6, 4'hB, 1'b0, 2'b01, 1'b1, 4'h6, 1'b0, 1'b0};
      vt[3] = '{2'b11, 4'h6, 4'hB, 1'b0, 2'b10, 1'b1, 4'hB, 1'b0, 1'b0};
      vt[4] = '{2'b01, 4'hC, 4'h0, 1'b0, 2'b01, 1'b0, 4'h0, 1'b0, 1'b0};
      vt[5] = '{2'b01, 4'h1, 4'h0, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0};
      vt[6] = '{2'b01, 4'h1, 4'h0, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         rd_req = vt[i].req; rd_addr0 = vt[i].a0; rd_addr1 = vt[i].a1;
         start = vt[i].st; clr_en = 1'b0;
         if (vt[i].gnt != 2'b00)
            rd_q.push_back(exp_rd(vt[i].gnt, vt[i].gnt[1] ? vt[i].a1 : vt[i].a0, 8'h10));
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", i), 32'(rd_gnt), 32'(vt[i].gnt));
         chk($sformatf("vec%0d_ctl", i), 32'({ram_cs, ram_we, busy, frame_done}),
             32'({vt[i].cs, 1'b0, vt[i].busy, vt[i].fd}));
         if (vt[i].cs) chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vt[i].addr));
         @(posedge clk); #1;
      end
      start = 1'b0; rd_req = 2'b00;
      for (int p = 0; p < 6; p++) begin
         pix_valid = 1'b1;
         pix_data  = 8'h20 + 8'(p);
         wr_q.push_back({2'(p / DX), 2'(p % DX), 8'h20 + 8'(p)});
         @(posedge clk); #1;
      end
      pix_data = 8'h26;
      #2 rst = 1'b1;
      #1;
      chk("async_reset_outputs", 32'({busy, frame_done, pix_ready, rd_gnt, rd_rvalid, rd_rerr,
                                      rd_rdata, ram_cs, ram_we, ram_wrAll}), 32'h0);
      pix_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int p = 0; p < 12; p++) begin
         pix_valid = 1'b1;
         pix_data  = 8'h30 + 8'(p);
         wr_q.push_back({2'(p / DX), 2'(p % DX), 8'h30 + 8'(p)});
         @(posedge clk); #1;
      end
      pix_valid = 1'b0;
      @(negedge clk);
      chk("reload_frame_done", 32'({frame_done, busy}), 32'b10);
      @(posedge clk); #1;
      rd_req = 2'b01; rd_addr0 = 4'h0;
      rd_q.push_back(exp_rd(2'b01, 4'h0, 8'h30));
      @(negedge clk);
      chk("reload_rd0_gnt", 32'(rd_gnt), 32'(2'b01));
      @(posedge clk); #1;
      rd_req = 2'b10; rd_addr1 = 4'hB;
      rd_q.push_back(exp_rd(2'b10, 4'hB, 8'h30));
      @(negedge clk);
      chk("reload_rd1_gnt", 32'(rd_gnt), 32'(2'b10));
      @(posedge clk); #1;
      rd_req = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("wr_queue_drained", 32'(wr_q.size()), 32'h0);
      chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
      chk("frame_done_count", 32'(fd_cnt), 32'h2);
   endtask

   int b_wr_cnt = 0, b_fd_cnt = 0, b_seq_err = 0, b_x = 0, b_y = 0;
   logic [BAW-1:0] b_last_addr = '0;

   // Monitor for the full-size instance: writes must follow raster order.
   always @(negedge clk) begin
      if (b_rst === 1'b0) begin
         if (b_ram_cs && b_ram_we && !b_ram_wrAll) begin
            if (b_ram_addr !== {9'(b_y), 9'(b_x)} || b_ram_wrData !== 8'(b_wr_cnt)) b_seq_err++;
            b_last_addr = b_ram_addr;
            b_wr_cnt++;
            b_x++;
            if (b_x == BX) begin
               b_x = 0; b_y++;
               if (b_y == BY) b_y = 0;
            end
         end
         if (b_frame_done) b_fd_cnt++;
      end
   end

   task automatic big_test();
      b_rst = 1'b1; b_start = 1'b0; b_clr_en = 1'b0; b_pix_valid = 1'b0; b_pix_data = 8'h00;
      b_rd_req = 2'b00; b_rd_addr0 = '0; b_rd_addr1 = '0;
      repeat (2) @(posedge clk);
      #1 b_rst = 1'b0;
      b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      b_pix_valid = 1'b1;
      for (int p = 0; p < BX * BY; p++) begin
         b_pix_data = 8'(p);
         @(posedge clk); #1;
      end
      b_pix_valid = 1'b0;
      for (int i = 0; i < 8 && b_fd_cnt == 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("big_frame_done_once", 32'(b_fd_cnt), 32'h1);
      chk("big_write_count", 32'(b_wr_cnt), 32'(BX * BY));
      chk("big_last_addr", 32'(b_last_addr), 32'({9'd299, 9'd299}));
      chk("big_seq_errors", 32'(b_seq_err), 32'h0);
      chk("big_serve_idle", 32'({b_busy, b_ram_cs, b_pix_ready}), 32'h0);
      @(posedge clk); #1 b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      b_pix_valid = 1'b1; b_pix_data = 8'h00;
      @(negedge clk);
      chk("big_counters_wrapped", 32'({b_ram_cs, b_ram_addr}), 32'({1'b1, 18'd0}));
      @(posedge clk); #1 b_pix_valid = 1'b0;
   endtask

   initial begin
      fork
         small_test();
         big_test();
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
